// File: rtl/mem_debug_reader_pkg.sv
// ---------------------------------------------------------------------------
// mem_debug_reader_pkg
//   Shared definitions for the memory debug dump block:
//   - state encoding (localparams plus the enum built on them)
//   - byte / word widths
//   - idx_width(): word-index width, clog2 of the word count, at least 1 bit
// ---------------------------------------------------------------------------
package mem_debug_reader_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;

   localparam logic [2:0] ENC_IDLE = 3'd0;
   localparam logic [2:0] ENC_ADDR = 3'd1;
   localparam logic [2:0] ENC_WAIT = 3'd2;
   localparam logic [2:0] ENC_SEND = 3'd3;
   localparam logic [2:0] ENC_NEXT = 3'd4;
   localparam logic [2:0] ENC_DONE = 3'd5;
   localparam logic [2:0] ENC_CSUM = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE = ENC_IDLE,
      ST_ADDR = ENC_ADDR,
      ST_WAIT = ENC_WAIT,
      ST_SEND = ENC_SEND,
      ST_NEXT = ENC_NEXT,
      ST_DONE = ENC_DONE,
      ST_CSUM = ENC_CSUM
   } state_e;

   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/mem_debug_reader_serializer.sv
// ---------------------------------------------------------------------------
// dbg_word_serializer
//   Holds one captured memory word and presents it a byte at a time,
//   most significant byte first.
//
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_word and point at byte 3
//   load_word  : word to capture
//   advance    : current byte has been transferred, step to the next one
//   byte_out   : currently selected byte
//   last_byte  : byte 0 is selected
// ---------------------------------------------------------------------------
module dbg_word_serializer
   import mem_debug_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] load_word,
   input  logic              advance,
   output logic [BYTE_W-1:0] byte_out,
   output logic              last_byte
);

   logic [WORD_W-1:0] hold_q, hold_d;
   logic [1:0]        ptr_q, ptr_d;

   always_comb begin
      hold_d = hold_q;
      ptr_d  = ptr_q;
      if (load) begin
         hold_d = load_word;
         ptr_d  = 2'd3;
      end else if (advance) begin
         ptr_d = ptr_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
         ptr_q  <= '0;
      end else begin
         hold_q <= hold_d;
         ptr_q  <= ptr_d;
      end
   end

   assign byte_out  = hold_q[{ptr_q, 3'b000} +: BYTE_W];
   assign last_byte = (ptr_q == 2'd0);

endmodule

// File: rtl/mem_debug_reader.sv
// ---------------------------------------------------------------------------
// mem_debug_reader
//   Dumps MEM_WORDS data-memory words through a byte-wide valid/ready sink.
//   Each word: drive the index, wait RD_LAT cycles for read data, capture,
//   then send its four bytes MSB first.
//
//   Optional build macro DUMP_CHECKSUM_EN: appends one trailer byte holding
//   the XOR of every dumped byte before the dump completes.
//
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle dump request, only honoured in IDLE
//   Debug_on        : puts the memory stage into debug-read mode
//   Debug_read_mem  : word index being read (zero-extended)
//   inMemDebug      : read data from the memory stage
//   tx_ready        : byte sink accepts tx_data this cycle
//   tx_valid,tx_data: byte offered to the sink
//   busy            : dump in progress
//   done            : one-cycle pulse as the dump finishes
//
//   state | meaning
//   IDLE  | waiting for start
//   ADDR  | index presented to memory
//   WAIT  | down-counting read latency, capture word at terminal count
//   SEND  | offering bytes 3..0 of the held word
//   NEXT  | last word? finish : bump index
//   CSUM  | offering the XOR trailer byte (DUMP_CHECKSUM_EN only)
//   DONE  | done pulse, back to IDLE
// ---------------------------------------------------------------------------
module mem_debug_reader
   import mem_debug_reader_pkg::*;
#(
   parameter int MEM_WORDS = 32,
   parameter int RD_LAT    = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              Debug_on,
   output logic [WORD_W-1:0] Debug_read_mem,
   input  logic [WORD_W-1:0] inMemDebug,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic [BYTE_W-1:0] tx_data,
   output logic              busy,
   output logic              done
);

   localparam int               IDX_W     = idx_width(MEM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MEM_WORDS - 1);
   localparam logic [1:0]       WAIT_LOAD = 2'(RD_LAT - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        wait_q, wait_d;
   logic              active_q, active_d;
   logic              tx_valid_q, tx_valid_d;
   logic              done_q, done_d;

   logic              ser_load;
   logic              ser_advance;
   logic [BYTE_W-1:0] ser_byte;
   logic              ser_last;
   logic              xfer;

`ifdef DUMP_CHECKSUM_EN
   logic [BYTE_W-1:0] csum_q, csum_d;
`endif

   assign xfer = tx_valid_q & tx_ready;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      wait_d      = wait_q;
      ser_load    = 1'b0;
      ser_advance = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = ST_ADDR;
`ifdef DUMP_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         ST_ADDR: begin
            wait_d  = WAIT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_q == 2'd0) begin
               ser_load = 1'b1;
               state_d  = ST_SEND;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               ser_advance = 1'b1;
`ifdef DUMP_CHECKSUM_EN
               csum_d      = csum_q ^ ser_byte;
`endif
               if (ser_last) state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (idx_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_DONE;
`endif
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_ADDR;
            end
         end
`ifdef DUMP_CHECKSUM_EN
         ST_CSUM: begin
            if (xfer) state_d = ST_DONE;
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      active_d   = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
`ifdef DUMP_CHECKSUM_EN
      tx_valid_d = (state_d == ST_SEND) || (state_d == ST_CSUM);
`else
      tx_valid_d = (state_d == ST_SEND);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         wait_q     <= '0;
         active_q   <= 1'b0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         wait_q     <= wait_d;
         active_q   <= active_d;
         tx_valid_q <= tx_valid_d;
         done_q     <= done_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   dbg_word_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (ser_load),
      .load_word (inMemDebug),
      .advance   (ser_advance),
      .byte_out  (ser_byte),
      .last_byte (ser_last)
   );

   assign Debug_on       = active_q;
   assign busy           = active_q;
   assign done           = done_q;
   assign tx_valid       = tx_valid_q;
   assign Debug_read_mem = {{(WORD_W-IDX_W){1'b0}}, idx_q};

   // tx_data is forced to zero whenever nothing is offered.
`ifdef DUMP_CHECKSUM_EN
   assign tx_data = !tx_valid_q          ? '0     :
                    (state_q == ST_CSUM) ? csum_q : ser_byte;
`else
   assign tx_data = tx_valid_q ? ser_byte : '0;
`endif

endmodule

// File: tb/tb_mem_debug_reader.sv
module tb_mem_debug_reader;

`ifdef DUMP_CHECKSUM_EN
   localparam int N_A     = 17;
   localparam int N_B     = 5;
   localparam int CYC_A   = 29;
   localparam int CYC_B   = 10;
`else
   localparam int N_A     = 16;
   localparam int N_B     = 4;
   localparam int CYC_A   = 28;
   localparam int CYC_B   = 9;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, tx_ready_a, start_b, tx_ready_b;
   logic        dbg_on_a, tx_valid_a, busy_a, done_a;
   logic        dbg_on_b, tx_valid_b, busy_b, done_b;
   logic [31:0] rd_a, rd_b, in_a, in_b;
   logic [7:0]  tx_data_a, tx_data_b;
   logic [31:0] pipe_b1, pipe_b2, pipe_b3;

   int n_total = 0;
   int n_pass  = 0;

   mem_debug_reader #(.MEM_WORDS(4), .RD_LAT(1)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .Debug_on(dbg_on_a),
      .Debug_read_mem(rd_a), .inMemDebug(in_a), .tx_ready(tx_ready_a),
      .tx_valid(tx_valid_a), .tx_data(tx_data_a), .busy(busy_a), .done(done_a)
   );

   mem_debug_reader #(.MEM_WORDS(1), .RD_LAT(3)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .Debug_on(dbg_on_b),
      .Debug_read_mem(rd_b), .inMemDebug(in_b), .tx_ready(tx_ready_b),
      .tx_valid(tx_valid_b), .tx_data(tx_data_b), .busy(busy_b), .done(done_b)
   );

   // Memory models: A has one cycle of read latency, B has three.
   always @(posedge clk) in_a <= 32'h11223344 + rd_a;
   always @(posedge clk) begin
      pipe_b1 <= (rd_b == 32'd0) ? 32'hDEADBEEF : 32'h0;
      pipe_b2 <= pipe_b1;
      pipe_b3 <= pipe_b2;
   end
   assign in_b = pipe_b3;

   // Monitors: byte transfers, done pulses, cycle count.
   int         cyc = 0;
   int         done_cnt_a = 0;
   int         done_cnt_b = 0;
   bit         rd_b_seen_nonzero = 1'b0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_valid_a && tx_ready_a) q_a.push_back(tx_data_a);
      if (tx_valid_b && tx_ready_b) q_b.push_back(tx_data_b);
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (done_b) done_cnt_b <= done_cnt_b + 1;
      if (rd_b != 32'd0) rd_b_seen_nonzero <= 1'b1;
   end

   function automatic logic [7:0] exp_a_byte(input int k);
      logic [31:0] w;
      if (k >= 16) return 8'h00;          // XOR trailer of the 16 bytes
      w = 32'h11223344 + 32'(k / 4);
      return w[8*(3 - (k % 4)) +: 8];
   endfunction

   function automatic logic [7:0] exp_b_byte(input int k);
      case (k)
         0: return 8'hDE;
         1: return 8'hAD;
         2: return 8'hBE;
         3: return 8'hEF;
         default: return 8'h22;           // DE^AD^BE^EF
      endcase
   endfunction

   task automatic kick(input bit sel_b, output int c0);
      @(negedge clk);
      if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      c0 = cyc;
   endtask

   task automatic wait_done(input bit sel_b, output int at_cyc, output bit ok);
      ok = 1'b0;
      at_cyc = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((sel_b ? done_b : done_a) === 1'b1) begin
            ok = 1'b1;
            at_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic wait_qsize_a(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q_a.size() == n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_total++; if (dbg_on_a !== 1'b0) $display("FAIL reset_dbg_on_a got %b want 0", dbg_on_a); else n_pass++;
      n_total++; if (rd_a !== 32'd0) $display("FAIL reset_rd_a got %h want 0", rd_a); else n_pass++;
      n_total++; if (tx_valid_a !== 1'b0) $display("FAIL reset_tx_valid_a got %b want 0", tx_valid_a); else n_pass++;
      n_total++; if (tx_data_a !== 8'h00) $display("FAIL reset_tx_data_a got %h want 00", tx_data_a); else n_pass++;
      n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy_a got %b want 0", busy_a); else n_pass++;
      n_total++; if (done_a !== 1'b0) $display("FAIL reset_done_a got %b want 0", done_a); else n_pass++;
      n_total++; if ({dbg_on_b, tx_valid_b, busy_b, done_b} !== 4'b0) $display("FAIL reset_ctrl_b got %b want 0000", {dbg_on_b, tx_valid_b, busy_b, done_b}); else n_pass++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_dump();
      int c0, cd, base, d0;
      bit ok;
      base = q_a.size();
      d0   = done_cnt_a;
      kick(1'b0, c0);
      n_total++; if (busy_a !== 1'b1 || dbg_on_a !== 1'b1) $display("FAIL dump_busy_rise got busy=%b dbg_on=%b want 1 1", busy_a, dbg_on_a); else n_pass++;
      n_total++; if (rd_a !== 32'd0) $display("FAIL dump_first_index got %h want 0", rd_a); else n_pass++;
      wait_done(1'b0, cd, ok);
      n_total++; if (!ok) $display("FAIL dump_done_timeout got no done want done"); else n_pass++;
      n_total++; if (cd - c0 !== CYC_A) $display("FAIL dump_cycles got %0d want %0d", cd - c0, CYC_A); else n_pass++;
      @(negedge clk);
      n_total++; if ({busy_a, dbg_on_a, done_a, tx_valid_a} !== 4'b0) $display("FAIL dump_idle_after got %b want 0000", {busy_a, dbg_on_a, done_a, tx_valid_a}); else n_pass++;
      n_total++; if (done_cnt_a - d0 !== 1) $display("FAIL dump_done_count got %0d want 1", done_cnt_a - d0); else n_pass++;
      n_total++; if (q_a.size() - base !== N_A) $display("FAIL dump_byte_count got %0d want %0d", q_a.size() - base, N_A); else n_pass++;
      for (int k = 0; k < N_A && base + k < q_a.size(); k++) begin
         n_total++;
         if (q_a[base + k] !== exp_a_byte(k)) $display("FAIL dump_byte%0d got %h want %h", k, q_a[base + k], exp_a_byte(k));
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int c0, cd, base;
      bit ok;
      base = q_a.size();
      kick(1'b0, c0);
      wait_qsize_a(base + 5, ok);
      n_total++; if (!ok) $display("FAIL bp_reach_timeout got no byte5 want byte5"); else n_pass++;
      tx_ready_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if (tx_valid_a !== 1'b1 || tx_data_a !== 8'h22)
            $display("FAIL bp_hold%0d got valid=%b data=%h want 1 22", i, tx_valid_a, tx_data_a);
         else n_pass++;
      end
      tx_ready_a = 1'b1;
      wait_done(1'b0, cd, ok);
      n_total++; if (cd - c0 !== CYC_A + 5) $display("FAIL bp_cycles got %0d want %0d", cd - c0, CYC_A + 5); else n_pass++;
      @(negedge clk);
      n_total++; if (q_a.size() - base !== N_A) $display("FAIL bp_byte_count got %0d want %0d", q_a.size() - base, N_A); else n_pass++;
      for (int k = 0; k < N_A && base + k < q_a.size(); k++) begin
         n_total++;
         if (q_a[base + k] !== exp_a_byte(k)) $display("FAIL bp_byte%0d got %h want %h", k, q_a[base + k], exp_a_byte(k));
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_dump();
      int c0, cd, base;
      bit ok;
      base = q_a.size();
      kick(1'b0, c0);
      wait_qsize_a(base + 5, ok);
      n_total++; if (!ok) $display("FAIL rstmid_reach_timeout got no byte5 want byte5"); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++; if ({dbg_on_a, tx_valid_a, busy_a, done_a} !== 4'b0) $display("FAIL rstmid_ctrl got %b want 0000", {dbg_on_a, tx_valid_a, busy_a, done_a}); else n_pass++;
      n_total++; if (rd_a !== 32'd0 || tx_data_a !== 8'h00) $display("FAIL rstmid_data got rd=%h tx=%h want 0 0", rd_a, tx_data_a); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_total++; if (busy_a !== 1'b0 || q_a.size() - base !== 5) $display("FAIL rstmid_no_resume got busy=%b bytes=%0d want 0 5", busy_a, q_a.size() - base); else n_pass++;
      base = q_a.size();
      kick(1'b0, c0);
      n_total++; if (rd_a !== 32'd0) $display("FAIL rstmid_restart_index got %h want 0", rd_a); else n_pass++;
      wait_done(1'b0, cd, ok);
      n_total++; if (cd - c0 !== CYC_A) $display("FAIL rstmid_cycles got %0d want %0d", cd - c0, CYC_A); else n_pass++;
      @(negedge clk);
      n_total++; if (q_a.size() - base !== N_A) $display("FAIL rstmid_byte_count got %0d want %0d", q_a.size() - base, N_A); else n_pass++;
      for (int k = 0; k < N_A && base + k < q_a.size(); k++) begin
         n_total++;
         if (q_a[base + k] !== exp_a_byte(k)) $display("FAIL rstmid_byte%0d got %h want %h", k, q_a[base + k], exp_a_byte(k));
         else n_pass++;
      end
   endtask

   task automatic test_start_ignored();
      int c0, cd, base, d0;
      bit ok;
      base = q_a.size();
      d0   = done_cnt_a;
      kick(1'b0, c0);
      repeat (10) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_done(1'b0, cd, ok);
      n_total++; if (!ok) $display("FAIL ign_done_timeout got no done want done"); else n_pass++;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (40) @(negedge clk);
      n_total++; if (done_cnt_a - d0 !== 1) $display("FAIL ign_done_count got %0d want 1", done_cnt_a - d0); else n_pass++;
      n_total++; if (q_a.size() - base !== N_A) $display("FAIL ign_byte_count got %0d want %0d", q_a.size() - base, N_A); else n_pass++;
      n_total++; if (busy_a !== 1'b0) $display("FAIL ign_busy_end got %b want 0", busy_a); else n_pass++;
   endtask

   task automatic test_single_word();
      int c0, cd, base;
      bit ok;
      base = q_b.size();
      kick(1'b1, c0);
      n_total++; if (busy_b !== 1'b1) $display("FAIL single_busy got %b want 1", busy_b); else n_pass++;
      wait_done(1'b1, cd, ok);
      n_total++; if (cd - c0 !== CYC_B) $display("FAIL single_cycles got %0d want %0d", cd - c0, CYC_B); else n_pass++;
      @(negedge clk);
      n_total++; if (q_b.size() - base !== N_B) $display("FAIL single_byte_count got %0d want %0d", q_b.size() - base, N_B); else n_pass++;
      for (int k = 0; k < N_B && base + k < q_b.size(); k++) begin
         n_total++;
         if (q_b[base + k] !== exp_b_byte(k)) $display("FAIL single_byte%0d got %h want %h", k, q_b[base + k], exp_b_byte(k));
         else n_pass++;
      end
      n_total++; if (rd_b_seen_nonzero !== 1'b0) $display("FAIL single_index_stays0 got nonzero want 0"); else n_pass++;
      n_total++; if (done_cnt_b !== 1) $display("FAIL single_done_count got %0d want 1", done_cnt_b); else n_pass++;
   endtask

   initial begin
      rst        = 1'b1;
      start_a    = 1'b0;
      start_b    = 1'b0;
      tx_ready_a = 1'b1;
      tx_ready_b = 1'b1;
      test_reset();
      test_dump();
      test_backpressure();
      test_reset_mid_dump();
      test_start_ignored();
      test_single_word();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
